spi_adc_reader: RTL and testbench
=================================

Name: spi_adc_reader

Overview:
- SPI master receive engine for the 12-bit serial ADC, CPOL=1, master samples on sclk rising edge.
- Triggered by the 100 us sample-period tick (`inicio`): runs one 16-bit read frame and presents the 12-bit sample with a one-cycle valid pulse.
- Sits between the sample-period timer and the sample consumer (display/filter path).

Parameters:
- DIV, 2, clk cycles per sclk half-period (DIV ≥ 1); 50 MHz / (2·2) = 12.5 MHz sclk.
- NBITS, 16, sclk cycles per frame: 4 leading zeros plus 12 data bits, MSB first.
- DATA_W, 12, width of the returned sample. These are the last DATA_W bits received.
- QUIET, 3, minimum clk cycles cs_n stays high before a new frame may begin.

Ports:
- clk, in, 1: system clock. All registers update on the rising edge.
- rst, in, 1: synchronous reset, active high.
- inicio, in, 1: frame request (sample tick). Rising-edge detected internally; a held level starts only one frame.
- miso, in, 1: ADC serial data.
- sclk, out, 1: SPI clock. Idles high.
- cs_n, out, 1: ADC chip select, active low.
- dato, out, DATA_W: last completed sample. Holds its value between frames.
- listo, out, 1: one-cycle pulse. Asserted the cycle dato updates.
- ocupado, out, 1: high while a frame or quiet time is in progress.
- fmt_err, out, 1: updated with dato. High if any of the NBITS-DATA_W leading bits was nonzero.
- perdido, out, 1: one-cycle pulse when an inicio rising edge is ignored because ocupado=1.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces the following. Reset mid-frame aborts the frame with no listo and leaves dato unchanged from 0.
  - state=IDLE, sclk=1, cs_n=1
  - dato=0, listo=0, ocupado=0, fmt_err=0, perdido=0
  - edge-detect register=0, counters=0
- Start accept: the rising edge of inicio is detected at edge k (inicio=1 and inicio_q=0) with state=IDLE.
  - From k+1: cs_n=0, ocupado=1.
- States:
  - IDLE: waits for an accepted start, then goes to SETUP.
  - SETUP: DIV cycles with sclk=1, cs_n=0, then goes to SHIFT.
  - SHIFT: NBITS sclk periods. Each period is DIV cycles with sclk=0 followed by DIV cycles with sclk=1.
    - miso is sampled into the shift register on the clk edge at which sclk goes 0→1, shifting left (MSB first).
    - A bit counter (width clog2(NBITS+1)) counts rising edges.
    - After the NBITS-th period completes, goes to HOLD.
  - HOLD: DIV cycles with sclk=1, cs_n=0, then goes to QUIET.
  - QUIET: cs_n=1, sclk=1 for QUIET cycles, then goes to IDLE; ocupado=0 from that edge.
- Completion, on the first cycle of QUIET:
  - dato = shreg[DATA_W-1:0].
  - fmt_err = |shreg[NBITS-1:DATA_W].
  - listo=1 for exactly that cycle.
- Frame timing, with DIV=2, NBITS=16, QUIET=3 and start detected at edge k:
  - cs_n low k+1..k+68 (2 + 64 + 2 cycles).
  - listo at k+69.
  - ocupado low from k+72.
  - First sclk falling edge at k+3.
- inicio edge while ocupado=1 (including during QUIET): ignored; perdido pulses for 1 cycle; the frame in progress is unaffected.
- inicio held high continuously: exactly one frame.
- Simultaneous rst and inicio: reset wins, and no frame starts.
- Divider counter width is clog2(DIV); it wraps to 0 at DIV-1.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding (IDLE, SETUP, SHIFT, HOLD, QUIET)
  - default DIV/NBITS/DATA_W/QUIET constants
  - ADC frame format constant (leading-zero count = NBITS-DATA_W)
- One natural sub-module: spi_sclk_gen.
  - DIV-based half-period counter.
  - Enabled in SHIFT.
  - Emits sclk plus single-cycle rise/fall strobes used by the FSM for sampling and bit counting.

Test Plan:
- Reset then single inicio pulse, ADC model drives 0x0ABC (0000_1010_1011_1100) → 16 sclk rising edges, cs_n low 68 cycles, listo at k+69, dato=0xABC, fmt_err=0.
- ADC model drives 0x8123 → dato=0x123, fmt_err=1, listo one cycle.
- inicio held high for 200 cycles → exactly one frame; one listo; perdido stays 0 (level, not new edge).
- Second inicio edge at k+30 and again at k+70 → perdido pulses at each; one listo only; next inicio at k+73 starts a frame normally.
- rst asserted at k+40 mid-SHIFT → next edge cs_n=1, sclk=1, ocupado=0, dato=0; no listo. A new inicio then completes a correct read.
- Back-to-back ticks every 5000 cycles for 4 frames with values 0x000, 0xFFF, 0x555, 0xAAA → each dato matches; sclk idles high between frames.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the serial ADC reader
package spi_pkg;

  // Default timing and frame geometry for the 12-bit ADC on a 50 MHz clock
  localparam int DIV_DEF    = 2;
  localparam int NBITS_DEF  = 16;
  localparam int DATA_W_DEF = 12;
  localparam int QUIET_DEF  = 3;

  // The ADC pads each sample with this many leading zero bits
  localparam int LEAD_DEF = NBITS_DEF - DATA_W_DEF;

  // Frame sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_QUIET = 3'd4;

endpackage

// File: rtl/spi_adc_reader_if.sv
// rtl/spi_adc_reader_if.sv - SPI pin bundle between the reader and the ADC
interface spi_adc_reader_if;
  logic sclk;
  logic cs_n;
  logic miso;

  modport master (output sclk, output cs_n, input miso);
  modport slave  (input sclk, input cs_n, output miso);
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period divider producing sclk and edge strobes
module spi_sclk_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  input  logic stop,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(DIV - 1));
  assign rise = en & last & ~sclk;
  assign fall = en & last & sclk;

  // Count half-periods; start drops sclk, stop holds it high on the final half-period
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (start) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      if (last) begin
        cnt  <= '0;
        sclk <= stop ? 1'b1 : ~sclk;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt  <= '0;
      sclk <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_adc_reader.sv
// rtl/spi_adc_reader.sv - one-shot SPI read of a 12-bit ADC sample per tick
module spi_adc_reader
  import spi_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int NBITS  = NBITS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int QUIET  = QUIET_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inicio,
  spi_adc_reader_if.master  spi,
  output logic [DATA_W-1:0] dato,
  output logic              listo,
  output logic              ocupado,
  output logic              fmt_err,
  output logic              perdido
);

  localparam int TMAX = (DIV > QUIET) ? DIV : QUIET;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(NBITS + 1);

  logic [2:0]       state;
  logic [TW-1:0]    tcnt;
  logic [BW-1:0]    bitcnt;
  logic [NBITS-1:0] shreg;
  logic             inicio_q;
  logic             cs_n_q;
  logic             start_edge;

  logic             sclk_w;
  logic             sclk_start;
  logic             sclk_en;
  logic             sclk_stop;
  logic             sclk_rise;
  logic             sclk_fall;

  assign start_edge = inicio & ~inicio_q;

  // sclk starts low on the same edge SETUP hands over to SHIFT
  assign sclk_start = (state == ST_SETUP) && (tcnt == TW'(DIV - 1));
  assign sclk_en    = (state == ST_SHIFT);
  assign sclk_stop  = (bitcnt == BW'(NBITS));

  spi_sclk_gen #(
    .DIV (DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst   (rst),
    .start (sclk_start),
    .en    (sclk_en),
    .stop  (sclk_stop),
    .sclk  (sclk_w),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign spi.sclk = sclk_w;
  assign spi.cs_n = cs_n_q;

  // Frame sequencer: start detect, shift-in on sclk rise, publish result on entering QUIET
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tcnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      inicio_q <= 1'b0;
      cs_n_q   <= 1'b1;
      dato     <= '0;
      listo    <= 1'b0;
      ocupado  <= 1'b0;
      fmt_err  <= 1'b0;
      perdido  <= 1'b0;
    end else begin
      inicio_q <= inicio;
      listo    <= 1'b0;
      perdido  <= start_edge && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state   <= ST_SETUP;
            cs_n_q  <= 1'b0;
            ocupado <= 1'b1;
            tcnt    <= '0;
            bitcnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (tcnt == TW'(DIV - 1)) begin
            tcnt  <= '0;
            state <= ST_SHIFT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            shreg  <= {shreg[NBITS-2:0], spi.miso};
            bitcnt <= bitcnt + BW'(1);
          end
          if (sclk_fall && sclk_stop) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tcnt == TW'(DIV - 1)) begin
            tcnt    <= '0;
            state   <= ST_QUIET;
            cs_n_q  <= 1'b1;
            listo   <= 1'b1;
            dato    <= shreg[DATA_W-1:0];
            fmt_err <= |shreg[NBITS-1:DATA_W];
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_QUIET: begin
          if (tcnt == TW'(QUIET - 1)) begin
            tcnt    <= '0;
            state   <= ST_IDLE;
            ocupado <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          cs_n_q  <= 1'b1;
          ocupado <= 1'b0;
          tcnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_reader.sv
// tb/tb_spi_adc_reader.sv - scoreboard bench for the SPI ADC reader
module tb_spi_adc_reader;
  import spi_pkg::*;

  localparam int LISTO_LAT = 2 + 16 * 2 * 2 + 2 + 1;

  typedef struct {
    logic [DATA_W_DEF-1:0] dato;
    logic                  fmt;
    int                    cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  inicio = 1'b0;
  logic [DATA_W_DEF-1:0] dato;
  logic                  listo;
  logic                  ocupado;
  logic                  fmt_err;
  logic                  perdido;

  spi_adc_reader_if spi_bus();

  spi_adc_reader #(
    .DIV (2), .NBITS (16), .DATA_W (12), .QUIET (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .spi     (spi_bus),
    .dato    (dato),
    .listo   (listo),
    .ocupado (ocupado),
    .fmt_err (fmt_err),
    .perdido (perdido)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          rises = 0;
  int          listo_cnt = 0;
  int          perd_cnt = 0;
  logic [15:0] adc_word = 16'h0000;
  int          adc_idx = 0;

  always @(posedge clk) begin
    cyc++;
    if (listo === 1'b1) listo_cnt++;
    if (perdido === 1'b1) perd_cnt++;
  end

  always @(posedge spi_bus.sclk) begin
    if (spi_bus.cs_n === 1'b0) rises++;
  end

  // ADC model: shifts MSB first on each sclk fall while selected
  always @(negedge spi_bus.sclk or posedge spi_bus.cs_n) begin
    if (spi_bus.cs_n === 1'b1) begin
      adc_idx = 0;
    end else if (adc_idx < 16) begin
      spi_bus.miso = adc_word[4'(15 - adc_idx)];
      adc_idx++;
    end
  end

  task automatic kick(input logic [15:0] w);
    exp_t e;
    adc_word = w;
    inicio   = 1'b1;
    e.dato   = w[DATA_W_DEF-1:0];
    e.fmt    = |w[NBITS_DEF-1:NBITS_DEF-LEAD_DEF];
    e.cyc    = cyc + LISTO_LAT;
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.dato = '0;
      e.fmt  = 1'b0;
      e.cyc  = -1;
    end
  endtask

  task automatic wait_listo(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (listo === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (ocupado === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    inicio = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (spi_bus.cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_cs_n: got %b want 1", spi_bus.cs_n); end
    vectors++; if (spi_bus.sclk !== 1'b1) begin miscompares++; $display("FAIL rst_sclk: got %b want 1", spi_bus.sclk); end
    vectors++; if (dato !== 12'h000) begin miscompares++; $display("FAIL rst_dato: got %h want 000", dato); end
    vectors++; if (listo !== 1'b0) begin miscompares++; $display("FAIL rst_listo: got %b want 0", listo); end
    vectors++; if (ocupado !== 1'b0) begin miscompares++; $display("FAIL rst_ocupado: got %b want 0", ocupado); end
    vectors++; if (fmt_err !== 1'b0) begin miscompares++; $display("FAIL rst_fmt_err: got %b want 0", fmt_err); end
    vectors++; if (perdido !== 1'b0) begin miscompares++; $display("FAIL rst_perdido: got %b want 0", perdido); end
    inicio = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inicio = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (spi_bus.cs_n !== 1'b1 || ocupado !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL rst_vs_inicio: got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_single();
    exp_t e;
    int   r0, csn_bad, lseen, c_at;
    logic [DATA_W_DEF-1:0] d_at;
    logic f_at, sclk2, sclk3, ocu1, ocu71, ocu72;
    bit   ok;
    @(negedge clk);
    r0 = rises; csn_bad = 0; lseen = 0; c_at = 0; d_at = '0; f_at = 1'b0;
    sclk2 = 1'b0; sclk3 = 1'b1; ocu1 = 1'b0; ocu71 = 1'b0; ocu72 = 1'b1;
    kick(16'h0ABC);
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      if (n == 1) begin inicio = 1'b0; ocu1 = ocupado; end
      if (n == 2) sclk2 = spi_bus.sclk;
      if (n == 3) sclk3 = spi_bus.sclk;
      if (n == 71) ocu71 = ocupado;
      if (n == 72) ocu72 = ocupado;
      if ((spi_bus.cs_n === 1'b0) != (n <= 68)) csn_bad++;
      if (listo === 1'b1) begin lseen++; d_at = dato; f_at = fmt_err; c_at = cyc; end
    end
    pop_exp(e);
    vectors++; if (csn_bad != 0) begin miscompares++; $display("FAIL single_cs_window: got %0d wrong cycles want 0", csn_bad); end
    vectors++; if (ocu1 !== 1'b1) begin miscompares++; $display("FAIL single_ocupado_k1: got %b want 1", ocu1); end
    vectors++; if (sclk2 !== 1'b1) begin miscompares++; $display("FAIL single_sclk_k2: got %b want 1", sclk2); end
    vectors++; if (sclk3 !== 1'b0) begin miscompares++; $display("FAIL single_sclk_k3: got %b want 0", sclk3); end
    vectors++; if (rises - r0 != 16) begin miscompares++; $display("FAIL single_rises: got %0d want 16", rises - r0); end
    vectors++; if (lseen != 1) begin miscompares++; $display("FAIL single_listo_count: got %0d want 1", lseen); end
    vectors++; if (c_at != e.cyc) begin miscompares++; $display("FAIL single_listo_cycle: got %0d want %0d", c_at, e.cyc); end
    vectors++; if (d_at !== e.dato) begin miscompares++; $display("FAIL single_dato: got %h want %h", d_at, e.dato); end
    vectors++; if (f_at !== e.fmt) begin miscompares++; $display("FAIL single_fmt_err: got %b want %b", f_at, e.fmt); end
    vectors++; if (ocu71 !== 1'b1) begin miscompares++; $display("FAIL single_ocupado_k71: got %b want 1", ocu71); end
    vectors++; if (ocu72 !== 1'b0) begin miscompares++; $display("FAIL single_ocupado_k72: got %b want 0", ocu72); end
    vectors++; if (dato !== e.dato) begin miscompares++; $display("FAIL single_dato_hold: got %h want %h", dato, e.dato); end
    wait_idle(20, ok);
  endtask

  task automatic test_fmt();
    exp_t e;
    bit   ok;
    @(negedge clk);
    kick(16'h8123);
    @(negedge clk);
    inicio = 1'b0;
    wait_listo(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL fmt_listo_timeout: got none want pulse"); end
    pop_exp(e);
    vectors++; if (dato !== e.dato) begin miscompares++; $display("FAIL fmt_dato: got %h want %h", dato, e.dato); end
    vectors++; if (fmt_err !== e.fmt) begin miscompares++; $display("FAIL fmt_err_flag: got %b want %b", fmt_err, e.fmt); end
    vectors++; if (cyc != e.cyc) begin miscompares++; $display("FAIL fmt_listo_cycle: got %0d want %0d", cyc, e.cyc); end
    @(negedge clk);
    vectors++; if (listo !== 1'b0) begin miscompares++; $display("FAIL fmt_listo_width: got %b want 0", listo); end
    wait_idle(20, ok);
  endtask

  task automatic test_held();
    exp_t e;
    int   lc0, pc0, c_at;
    logic [DATA_W_DEF-1:0] d_at;
    logic f_at;
    @(negedge clk);
    lc0 = listo_cnt; pc0 = perd_cnt; c_at = 0; d_at = '0; f_at = 1'b1;
    kick(16'h0456);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (listo === 1'b1) begin d_at = dato; f_at = fmt_err; c_at = cyc; end
    end
    inicio = 1'b0;
    repeat (5) @(negedge clk);
    pop_exp(e);
    vectors++; if (listo_cnt - lc0 != 1) begin miscompares++; $display("FAIL held_listo_count: got %0d want 1", listo_cnt - lc0); end
    vectors++; if (perd_cnt - pc0 != 0) begin miscompares++; $display("FAIL held_perdido: got %0d want 0", perd_cnt - pc0); end
    vectors++; if (d_at !== e.dato) begin miscompares++; $display("FAIL held_dato: got %h want %h", d_at, e.dato); end
    vectors++; if (f_at !== e.fmt) begin miscompares++; $display("FAIL held_fmt_err: got %b want %b", f_at, e.fmt); end
    vectors++; if (c_at != e.cyc) begin miscompares++; $display("FAIL held_listo_cycle: got %0d want %0d", c_at, e.cyc); end
  endtask

  task automatic test_overlap();
    exp_t e;
    int   lseen, pc0;
    logic p31, p71, csn74;
    bit   ok;
    @(negedge clk);
    lseen = 0; pc0 = perd_cnt; p31 = 1'b0; p71 = 1'b0; csn74 = 1'b1;
    kick(16'h0321);
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (n == 31) p31 = perdido;
      if (n == 71) p71 = perdido;
      if (n == 74) csn74 = spi_bus.cs_n;
      if (n == 1 || n == 31 || n == 71 || n == 74) inicio = 1'b0;
      if (n == 30 || n == 70) inicio = 1'b1;
      if (n == 73) kick(16'h0DEF);
      if (listo === 1'b1) begin
        lseen++;
        pop_exp(e);
        vectors++; if (dato !== e.dato) begin miscompares++; $display("FAIL overlap_dato: got %h want %h", dato, e.dato); end
        vectors++; if (fmt_err !== e.fmt) begin miscompares++; $display("FAIL overlap_fmt_err: got %b want %b", fmt_err, e.fmt); end
        vectors++; if (cyc != e.cyc) begin miscompares++; $display("FAIL overlap_listo_cycle: got %0d want %0d", cyc, e.cyc); end
      end
    end
    vectors++; if (p31 !== 1'b1) begin miscompares++; $display("FAIL overlap_perdido_k31: got %b want 1", p31); end
    vectors++; if (p71 !== 1'b1) begin miscompares++; $display("FAIL overlap_perdido_k71: got %b want 1", p71); end
    vectors++; if (perd_cnt - pc0 != 2) begin miscompares++; $display("FAIL overlap_perdido_count: got %0d want 2", perd_cnt - pc0); end
    vectors++; if (csn74 !== 1'b0) begin miscompares++; $display("FAIL overlap_restart_cs_n: got %b want 0", csn74); end
    vectors++; if (lseen != 2) begin miscompares++; $display("FAIL overlap_listo_count: got %0d want 2", lseen); end
    wait_idle(20, ok);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lc0;
    bit   ok;
    @(negedge clk);
    lc0 = listo_cnt;
    kick(16'h0777);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) inicio = 1'b0;
      if (n == 40) rst = 1'b1;
    end
    @(negedge clk);
    void'(sb.pop_back());
    vectors++; if (spi_bus.cs_n !== 1'b1) begin miscompares++; $display("FAIL midrst_cs_n: got %b want 1", spi_bus.cs_n); end
    vectors++; if (spi_bus.sclk !== 1'b1) begin miscompares++; $display("FAIL midrst_sclk: got %b want 1", spi_bus.sclk); end
    vectors++; if (ocupado !== 1'b0) begin miscompares++; $display("FAIL midrst_ocupado: got %b want 0", ocupado); end
    vectors++; if (dato !== 12'h000) begin miscompares++; $display("FAIL midrst_dato: got %h want 000", dato); end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    vectors++; if (listo_cnt != lc0) begin miscompares++; $display("FAIL midrst_no_listo: got %0d pulses want 0", listo_cnt - lc0); end
    kick(16'h0BCD);
    @(negedge clk);
    inicio = 1'b0;
    wait_listo(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_listo_timeout: got none want pulse"); end
    pop_exp(e);
    vectors++; if (dato !== e.dato) begin miscompares++; $display("FAIL midrst_dato_after: got %h want %h", dato, e.dato); end
    vectors++; if (cyc != e.cyc) begin miscompares++; $display("FAIL midrst_listo_cycle: got %0d want %0d", cyc, e.cyc); end
    wait_idle(20, ok);
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] words [4];
    int          got, idle_bad;
    words[0] = 16'h0000; words[1] = 16'h0FFF; words[2] = 16'h0555; words[3] = 16'h0AAA;
    got = 0; idle_bad = 0;
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      kick(words[f]);
      for (int n = 1; n < 5000; n++) begin
        @(negedge clk);
        if (n == 1) inicio = 1'b0;
        if (spi_bus.cs_n === 1'b1 && spi_bus.sclk !== 1'b1) idle_bad++;
        if (listo === 1'b1) begin
          got++;
          pop_exp(e);
          vectors++; if (dato !== e.dato) begin miscompares++; $display("FAIL b2b_dato: got %h want %h", dato, e.dato); end
          vectors++; if (fmt_err !== e.fmt) begin miscompares++; $display("FAIL b2b_fmt_err: got %b want %b", fmt_err, e.fmt); end
          vectors++; if (cyc != e.cyc) begin miscompares++; $display("FAIL b2b_listo_cycle: got %0d want %0d", cyc, e.cyc); end
        end
      end
    end
    vectors++; if (got != 4) begin miscompares++; $display("FAIL b2b_frames: got %0d want 4", got); end
    vectors++; if (idle_bad != 0) begin miscompares++; $display("FAIL b2b_sclk_idle: got %0d low cycles want 0", idle_bad); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_scoreboard_left: got %0d want 0", sb.size()); end
  endtask

  initial begin
    spi_bus.miso = 1'b0;
    test_reset();
    test_single();
    test_fmt();
    test_held();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
